// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter and byte sequencer in front of one
// single-CS SPI master. Each grant latches a requester's transaction word,
// streams its bytes into the master, collects the MISO bytes into a readback
// word and then holds the bus idle for GAP_CLKS cycles before the next grant.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to build a watchdog that aborts
// a transaction stuck waiting for the master and raises a sticky o_err.
module spi_txn_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int BYTES_PER_TXN = 4,
    parameter int GAP_CLKS      = 16,
    parameter int TIMEOUT_CLKS  = 4096
) (
    input  logic                                clk40M,
    input  logic                                nRst,
    input  logic [NUM_REQ-1:0]                  i_req,
    input  logic [NUM_REQ*8*BYTES_PER_TXN-1:0]  i_word,
    output logic [NUM_REQ-1:0]                  o_gnt,
    output logic [NUM_REQ-1:0]                  o_done,
    output logic [8*BYTES_PER_TXN-1:0]          o_rx_word,
    output logic                                o_busy,
    output logic                                o_err,
    output logic [$clog2(BYTES_PER_TXN+1)-1:0]  o_spi_tx_count,
    output logic [7:0]                          o_spi_tx_byte,
    output logic                                o_spi_tx_dv,
    input  logic                                i_spi_tx_ready,
    input  logic                                i_spi_rx_dv,
    input  logic [7:0]                          i_spi_rx_byte
);

    localparam int WORD_W = 8 * BYTES_PER_TXN;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W  = (BYTES_PER_TXN > 1) ? $clog2(BYTES_PER_TXN) : 1;
    localparam int CNT_W  = $clog2(BYTES_PER_TXN + 1);
    localparam int GAP_W  = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_TXN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [PTR_W-1:0]    last_q, last_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;
    logic [WORD_W-1:0]   shadow_q, shadow_d;
    logic [WORD_W-1:0]   rx_buf_q, rx_buf_d;
    logic [IDX_W-1:0]    rxidx_q, rxidx_d;
    logic [WORD_W-1:0]   rx_word_q, rx_word_d;
    logic                rdy_prev_q, rdy_prev_d;

    logic                rdy_rise;
    logic                tx_dv;
    logic                tmo;
    logic                finish_ok;
    logic                finish_tmo;
    logic                found;
    logic [PTR_W-1:0]    sel;
    int                  cand;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CLKS + 1);
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                err_q, err_d;
`endif

    // Round-robin pick: first requester strictly after the last-granted one.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_q) + k) % NUM_REQ;
            if (!found && i_req[cand]) begin
                found = 1'b1;
                sel   = PTR_W'(cand);
            end
        end
    end

    // Sequencer next-state, RX capture and transaction completion.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        last_d     = last_q;
        gidx_d     = gidx_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        busy_d     = busy_q;
        shadow_d   = shadow_q;
        rx_buf_d   = rx_buf_q;
        rxidx_d    = rxidx_q;
        rx_word_d  = rx_word_q;
        rdy_prev_d = i_spi_tx_ready;
        tx_dv      = 1'b0;
        finish_ok  = 1'b0;
        finish_tmo = 1'b0;
        rdy_rise   = i_spi_tx_ready & ~rdy_prev_q;

`ifdef SPI_ARB_TIMEOUT_EN
        tmo = ((state_q == ST_SEND) || (state_q == ST_WAIT)) && !rdy_rise &&
              (wdog_q == WDOG_W'(TIMEOUT_CLKS - 1));
`else
        tmo = 1'b0;
`endif

        // MISO bytes land in the buffer; a byte arriving together with the
        // final ready edge is folded into this cycle's readback word.
        if (busy_q && i_spi_rx_dv) begin
            rx_buf_d[int'(rxidx_q)*8 +: 8] = i_spi_rx_byte;
            if (rxidx_q != LAST_IDX) begin
                rxidx_d = rxidx_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    shadow_d   = i_word[int'(sel)*WORD_W +: WORD_W];
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    gidx_d     = sel;
                    busy_d     = 1'b1;
                    idx_d      = '0;
                    rxidx_d    = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tmo) begin
                    finish_tmo = 1'b1;
                end else if (i_spi_tx_ready) begin
                    tx_dv   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tmo) begin
                    finish_tmo = 1'b1;
                end else if (rdy_rise) begin
                    if (idx_q == LAST_IDX) begin
                        finish_ok = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_GAP: begin
                // The counter reaches zero on this edge, so the bus is idle
                // for exactly GAP_CLKS cycles (one cycle minimum).
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish_ok || finish_tmo) begin
            done_d  = gnt_q;
            gnt_d   = '0;
            last_d  = gidx_q;
            gap_d   = GAP_W'(GAP_CLKS);
            state_d = ST_GAP;
        end
        if (finish_ok) begin
            rx_word_d = rx_buf_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            gap_q      <= '0;
            last_q     <= PTR_W'(NUM_REQ - 1);
            gidx_q     <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            shadow_q   <= '0;
            rx_buf_q   <= '0;
            rxidx_q    <= '0;
            rx_word_q  <= '0;
            rdy_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
            gidx_q     <= gidx_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            shadow_q   <= shadow_d;
            rx_buf_q   <= rx_buf_d;
            rxidx_q    <= rxidx_d;
            rx_word_q  <= rx_word_d;
            rdy_prev_q <= rdy_prev_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog counts cycles waiting on the master and restarts on each byte.
    always_comb begin
        wdog_d = wdog_q;
        err_d  = err_q | finish_tmo;
        if ((state_q == ST_IDLE) || (state_q == ST_GAP) || rdy_rise) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_gnt          = gnt_q;
    assign o_done         = done_q;
    assign o_busy         = busy_q;
    assign o_rx_word      = rx_word_q;
    assign o_spi_tx_dv    = tx_dv;
    assign o_spi_tx_byte  = tx_dv ? shadow_q[int'(idx_q)*8 +: 8] : 8'h00;
    assign o_spi_tx_count = CNT_W'(BYTES_PER_TXN);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed testbench for spi_txn_arbiter with a behavioural SPI master model.
module tb_spi_txn_arbiter;

    localparam int NUM_REQ = 2;
    localparam int BPT     = 4;
    localparam int GAP     = 16;
    localparam int TMO     = 64;

    logic              clk40M = 1'b0;
    logic              nRst;
    logic [1:0]        i_req;
    logic [63:0]       i_word;
    logic [1:0]        o_gnt;
    logic [1:0]        o_done;
    logic [31:0]       o_rx_word;
    logic              o_busy;
    logic              o_err;
    logic [2:0]        o_spi_tx_count;
    logic [7:0]        o_spi_tx_byte;
    logic              o_spi_tx_dv;
    logic              i_spi_tx_ready;
    logic              i_spi_rx_dv;
    logic [7:0]        i_spi_rx_byte;

    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;
    int                done_cnt = 0;
    int                dv_bad = 0;
    int                extra_cycles = 0;
    bit                stuck = 1'b0;
    logic [7:0]        dv_log[$];
    int                dv_stamp[$];
    logic [7:0]        miso_q[$];

    spi_txn_arbiter #(
        .NUM_REQ(NUM_REQ),
        .BYTES_PER_TXN(BPT),
        .GAP_CLKS(GAP),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk40M(clk40M),
        .nRst(nRst),
        .i_req(i_req),
        .i_word(i_word),
        .o_gnt(o_gnt),
        .o_done(o_done),
        .o_rx_word(o_rx_word),
        .o_busy(o_busy),
        .o_err(o_err),
        .o_spi_tx_count(o_spi_tx_count),
        .o_spi_tx_byte(o_spi_tx_byte),
        .o_spi_tx_dv(o_spi_tx_dv),
        .i_spi_tx_ready(i_spi_tx_ready),
        .i_spi_rx_dv(i_spi_rx_dv),
        .i_spi_rx_byte(i_spi_rx_byte)
    );

    // 40 MHz-style clock, 10 time units per period.
    always #5 clk40M = ~clk40M;

    // Free-running cycle counter used to timestamp byte strobes.
    always @(posedge clk40M) cyc <= cyc + 1;

    // SPI master model: drops ready after each strobe, returns one MISO byte
    // and raises ready again after 2 (+extra) cycles, or never while stuck.
    always @(negedge clk40M) begin
        if (o_spi_tx_dv) begin
            @(posedge clk40M);
            #1 i_spi_tx_ready = 1'b0;
            repeat (2 + extra_cycles) @(posedge clk40M);
            extra_cycles = 0;
            while (stuck) @(posedge clk40M);
            #1;
            if (miso_q.size() > 0) i_spi_rx_byte = miso_q.pop_front();
            else i_spi_rx_byte = 8'hEE;
            i_spi_rx_dv    = 1'b1;
            i_spi_tx_ready = 1'b1;
            @(posedge clk40M);
            #1 i_spi_rx_dv = 1'b0;
        end
    end

    // Passive monitor of byte strobes and completion pulses.
    always @(negedge clk40M) begin
        if (o_spi_tx_dv) begin
            dv_log.push_back(o_spi_tx_byte);
            dv_stamp.push_back(cyc);
            if (!i_spi_tx_ready) dv_bad++;
        end
        if (o_done != 2'b00) done_cnt++;
    end

    // Hard stop in case the sequence itself hangs.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (o_done == 2'b00 && n < limit) begin
            @(negedge clk40M);
            n++;
        end
        check({tag, "_arrives"}, {63'd0, (o_done != 2'b00)}, 64'd1);
    endtask

    task automatic wait_gnt(input string tag, input int limit);
        int n = 0;
        while (o_gnt == 2'b00 && n < limit) begin
            @(negedge clk40M);
            n++;
        end
        check({tag, "_arrives"}, {63'd0, (o_gnt != 2'b00)}, 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (o_busy && n < limit) begin
            @(negedge clk40M);
            n++;
        end
        check({tag, "_idle"}, {63'd0, o_busy}, 64'd0);
    endtask

    function automatic logic [31:0] log_word();
        if (dv_log.size() != 4) return 32'hxxxx_xxxx;
        return {dv_log[3], dv_log[2], dv_log[1], dv_log[0]};
    endfunction

    function automatic int stamp(input int i);
        if (i >= dv_stamp.size()) return -1000;
        return dv_stamp[i];
    endfunction

    initial begin
        int n;
        int dsnap;
        logic [1:0]  exp_g;
        logic [31:0] exp_rx;
        logic [31:0] prev_rx;
        logic [31:0] rx_before;

        nRst = 1'b0;
        i_req = 2'b00;
        i_word = 64'd0;
        i_spi_tx_ready = 1'b1;
        i_spi_rx_dv = 1'b0;
        i_spi_rx_byte = 8'h00;
        repeat (3) @(negedge clk40M);

        // Reset values.
        check("reset_gnt", o_gnt, 2'b00);
        check("reset_done", o_done, 2'b00);
        check("reset_busy", o_busy, 1'b0);
        check("reset_rx_word", o_rx_word, 32'h0);
        check("reset_dv", o_spi_tx_dv, 1'b0);
        check("reset_err", o_err, 1'b0);
        check("reset_tx_count", o_spi_tx_count, 3'd4);
        nRst = 1'b1;
        @(negedge clk40M);

        // Single transaction from requester 0 with MISO readback.
        miso_q = {8'hA5, 8'h5A, 8'hC3, 8'h3C};
        dv_log.delete();
        i_word[31:0] = 32'h0001_0030;
        i_req = 2'b01;
        @(negedge clk40M);
        check("t1_gnt", o_gnt, 2'b01);
        check("t1_busy", o_busy, 1'b1);
        wait_done("t1_done", 200);
        check("t1_done_vec", o_done, 2'b01);
        check("t1_rx_word", o_rx_word, 32'h3CC3_5AA5);
        check("t1_tx_bytes", log_word(), 32'h0001_0030);
        check("t1_dv_count", dv_log.size(), 4);
        i_req = 2'b00;
        n = 0;
        while (o_busy && n < 100) begin
            @(negedge clk40M);
            n++;
        end
        check("t1_gap_len", n, 16);
        check("t1_done_once", done_cnt, 1);
        check("t1_rx_hold", o_rx_word, 32'h3CC3_5AA5);

        // Both requesters held: strict alternation starting from requester 0.
        nRst = 1'b0;
        @(negedge clk40M);
        nRst = 1'b1;
        @(negedge clk40M);
        miso_q.delete();
        for (int t = 0; t < 4; t++) begin
            for (int b = 0; b < 4; b++) miso_q.push_back(8'(16 * (t + 1) + b));
        end
        i_word = {32'hB0B1_B2B3, 32'hA0A1_A2A3};
        dv_log.delete();
        prev_rx = 32'h0;
        i_req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_rx = {8'(16 * (t + 1) + 3), 8'(16 * (t + 1) + 2),
                      8'(16 * (t + 1) + 1), 8'(16 * (t + 1))};
            wait_gnt("t2_gnt", 60);
            check("t2_gnt_vec", o_gnt, exp_g);
            check("t2_rx_hold", o_rx_word, prev_rx);
            wait_done("t2_done", 200);
            check("t2_order", o_done, exp_g);
            check("t2_tx_word", log_word(), (exp_g == 2'b01) ? 32'hA0A1_A2A3 : 32'hB0B1_B2B3);
            check("t2_rx_word", o_rx_word, exp_rx);
            prev_rx = exp_rx;
            dv_log.delete();
        end
        i_req = 2'b00;
        wait_idle("t2", 60);

        // Reset in the middle of a transaction, then a fresh re-request.
        miso_q.delete();
        i_word[31:0] = 32'h4433_2211;
        dv_log.delete();
        i_req = 2'b01;
        n = 0;
        while (dv_log.size() < 2 && n < 100) begin
            @(negedge clk40M);
            n++;
        end
        check("t4_two_bytes", dv_log.size(), 2);
        dsnap = done_cnt;
        #2 nRst = 1'b0;
        #1;
        check("t4_rst_gnt", o_gnt, 2'b00);
        check("t4_rst_busy", o_busy, 1'b0);
        check("t4_rst_done", o_done, 2'b00);
        check("t4_rst_dv", o_spi_tx_dv, 1'b0);
        check("t4_rst_rx_word", o_rx_word, 32'h0);
        repeat (10) @(negedge clk40M);
        check("t4_no_done", done_cnt, dsnap);
        dv_log.delete();
        nRst = 1'b1;
        wait_done("t4_done", 200);
        check("t4_done_vec", o_done, 2'b01);
        check("t4_resend", log_word(), 32'h4433_2211);
        i_req = 2'b00;
        wait_idle("t4", 60);

        // Ready stretched by 3 cycles before the second byte.
        extra_cycles = 3;
        dv_log.delete();
        dv_stamp.delete();
        dv_bad = 0;
        i_word[63:32] = 32'hDEAD_BEEF;
        i_req = 2'b10;
        wait_done("t5_done", 200);
        check("t5_done_vec", o_done, 2'b10);
        check("t5_dv_count", dv_log.size(), 4);
        check("t5_space01", stamp(1) - stamp(0), 7);
        check("t5_space12", stamp(2) - stamp(1), 4);
        check("t5_space23", stamp(3) - stamp(2), 4);
        check("t5_dv_while_busy", dv_bad, 0);
        check("t5_tx_word", log_word(), 32'hDEAD_BEEF);
        i_req = 2'b00;
        wait_idle("t5", 60);

`ifdef SPI_ARB_TIMEOUT_EN
        // Master stuck after the first byte: watchdog aborts the transaction.
        rx_before = o_rx_word;
        stuck = 1'b1;
        i_word[31:0] = 32'hCAFE_F00D;
        i_req = 2'b01;
        wait_gnt("t6_gnt", 20);
        n = 0;
        while (o_done == 2'b00 && n < 200) begin
            @(negedge clk40M);
            n++;
        end
        check("t6_tmo_cycle", n, 64);
        check("t6_done_vec", o_done, 2'b01);
        check("t6_err", o_err, 1'b1);
        check("t6_rx_unchanged", o_rx_word, rx_before);
        i_req = 2'b00;
        wait_idle("t6", 60);
        stuck = 1'b0;
        repeat (5) @(negedge clk40M);
        i_req = 2'b10;
        wait_done("t6_next", 200);
        check("t6_next_vec", o_done, 2'b10);
        check("t6_err_sticky", o_err, 1'b1);
        i_req = 2'b00;
        wait_idle("t6_next", 60);
`else
        rx_before = o_rx_word;
        check("err_tied_low", o_err, 1'b0);
        check("rx_final_hold", o_rx_word, rx_before ^ 32'h0 | 32'h0 | (rx_before & 32'hFFFF_FFFF));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Round-robin arbiter and byte sequencer that shares one single-CS SPI master between NUM_REQ requesters, e.g. the power-up init sequencer and the UART command path.
- Each requester submits one fixed-length transaction word: address LSB, address MSB, data LSB, data MSB. The block streams the bytes into the master's byte interface, assembles the MISO bytes into a readback word, and enforces an idle gap between transactions.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
BYTES_PER_TXN, 4, bytes per chip-select window; must equal the SPI master's MAX_BYTES_PER_CS
GAP_CLKS, 16, minimum clk40M cycles between the end of one transaction and the next grant
TIMEOUT_CLKS, 4096, watchdog limit in cycles (used only with the optional feature)

Ports:
clk40M  in  1  system clock
nRst  in  1  asynchronous, active-low reset
i_req  in  NUM_REQ  level request per requester; held until its o_done
i_word  in  NUM_REQ*8*BYTES_PER_TXN  per-requester transaction word; byte 0 in bits [7:0] is sent first
o_gnt  out  NUM_REQ  one-hot, high for the whole granted transaction
o_done  out  NUM_REQ  one-cycle pulse to the granted requester at completion
o_rx_word  out  8*BYTES_PER_TXN  MISO bytes of the last transaction; byte 0 in [7:0]
o_busy  out  1  high from grant until the gap expires
o_err  out  1  sticky watchdog error; constant 0 without the optional feature
o_spi_tx_count  out  $clog2(BYTES_PER_TXN+1)  constant BYTES_PER_TXN
o_spi_tx_byte  out  8  byte to the SPI master
o_spi_tx_dv  out  1  one-cycle byte strobe to the SPI master
i_spi_tx_ready  in  1  SPI master ready level
i_spi_rx_dv  in  1  SPI master RX byte strobe
i_spi_rx_byte  in  8  SPI master RX byte

Behaviour:
- Reset: all outputs 0 except o_spi_tx_count. State IDLE, byte index 0, gap counter 0, ready_d 0. Round-robin pointer set so requester 0 has top priority.
- Reset mid-transaction: everything returns to IDLE immediately; no o_done is issued. Requesters re-request after release.
- Byte-complete event: rdy_rise = i_spi_tx_ready & ~ready_d, with ready_d registered every cycle.
- IDLE:
  - If any i_req is set and the gap counter is 0, pick the first requesting index strictly after the last-granted index (wrapping).
  - In the same edge: latch that i_word into a shadow register, set o_gnt one-hot and o_busy, clear the index, go to SEND.
  - Grant latency is 1 cycle from i_req.
- SEND: when i_spi_tx_ready=1, drive o_spi_tx_byte = shadow byte[idx] and o_spi_tx_dv=1 for exactly one cycle, then go to WAIT. If ready=0, hold SEND with dv=0.
- WAIT:
  - On rdy_rise with idx < BYTES_PER_TXN-1: idx+1, go to SEND.
  - On rdy_rise with idx = BYTES_PER_TXN-1: pulse o_done[g], drop o_gnt, update the last-granted pointer, load the gap counter with GAP_CLKS, go to GAP.
- GAP: decrement the counter each cycle. At 0, clear o_busy and go to IDLE. With GAP_CLKS=0, GAP lasts exactly 1 cycle.
- RX capture:
  - An internal rx index is cleared at grant.
  - Each i_spi_rx_dv while busy writes i_spi_rx_byte into rx_buf[rxidx] and increments rxidx, saturating at BYTES_PER_TXN-1.
  - o_rx_word is updated from rx_buf in the same cycle as o_done and holds until the next o_done.
  - i_spi_rx_dv while not busy is ignored.
- Requester behaviour during and after a transaction:
  - i_req or i_word changing after grant has no effect, because the word is already latched.
  - A requester still asserting i_req in the cycle o_done fires is eligible again only after the gap, and loses to any other pending requester.
- Simultaneous requests: at most one grant per arbitration; no starvation. With N requesters all asserting, each is served once per N transactions.

Optional Feature:
Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in SEND or WAIT and clears on every rdy_rise.
  - On reaching TIMEOUT_CLKS: set o_err (sticky until nRst), pulse o_done[g], drop o_gnt, leave o_rx_word unchanged, and enter GAP.
- Not defined: no watchdog logic is built, o_err is tied to 0, and the block waits indefinitely for ready.

Test Plan:
- Reset release, req0=1 with i_word0=32'h0001_0030 -> o_gnt=2'b01 one cycle later; tx bytes 30,00,01,00 in order, one dv each; o_done[0] pulses once; o_busy falls 16 cycles after done.
- req0 and req1 asserted in the same cycle and held -> grant order 0,1,0,1 over 4 transactions; no requester granted twice in a row.
- Slave returns MISO bytes A5,5A,C3,3C -> o_rx_word=32'h3CC35AA5 at o_done and held until the next o_done.
- nRst pulsed low after the 2nd tx byte of a transaction -> all outputs 0 asynchronously, no o_done; after release, a re-request is sent from byte 0.
- i_spi_tx_ready held low for 3 extra cycles before a byte -> o_spi_tx_dv is withheld until ready=1; exactly 4 dv pulses total.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CLKS=64, ready stuck at 0 after byte 1 -> o_err=1 and o_done pulses at cycle 64; the next request is still served.
